gpa_spi_serialiser: RTL and testbench



---
 rtl/gpa_spi_serialiser.sv | 177 +++++++++++++++++
 tb/tb_gpa_spi_serialiser.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpa_spi_serialiser.sv
// Multi-channel SPI serialiser for the gradient DAC boards, with a one-word pending slot.
// Define GPA_SPI_READBACK_EN to add the sdi_i/rdata_o/rvalid_o readback path.
module gpa_spi_serialiser #(
  parameter int NCH    = 4,
  parameter int W      = 24,
  parameter int DIV    = 16,
  parameter int LDAC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             sclk_o,
  output logic             syncn_o,
  output logic             ldacn_o,
  output logic [NCH-1:0]   sdo_o
`ifdef GPA_SPI_READBACK_EN
  ,
  input  logic [NCH-1:0]   sdi_i,
  output logic [NCH*W-1:0] rdata_o,
  output logic             rvalid_o
`endif
);

  // state  | meaning
  // IDLE   | no frame; loads the pending slot when it is full
  // SHIFT  | W bit periods of 2*DIV cycles, syncn low
  // SYNCHI | one cycle with syncn high
  // LDAC   | ldacn low for LDAC_W cycles; may load the next frame directly

  localparam int PW  = $clog2(2 * DIV);
  localparam int BW  = $clog2(W);
  localparam int LCW = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;
  localparam logic [PW-1:0]  PER_MAX  = PW'(2 * DIV - 1);
  localparam logic [PW-1:0]  DIV_C    = PW'(DIV);
  localparam logic [BW-1:0]  BIT_MAX  = BW'(W - 1);
  localparam logic [LCW-1:0] LDAC_MAX = LCW'((LDAC_W > 0) ? LDAC_W - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, SYNCHI, LDAC} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    per_cnt, per_nx;
  logic [BW-1:0]    bit_cnt, bit_nx;
  logic [LCW-1:0]   ldac_cnt, ldac_nx;
  logic [NCH*W-1:0] shreg, shreg_nx, slot;
  logic             slot_full, slot_full_nx;
  logic             accept, load;
  logic [NCH-1:0]   sdo_nx;

  assign accept = valid_i && ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    per_nx   = per_cnt;
    bit_nx   = bit_cnt;
    ldac_nx  = ldac_cnt;
    shreg_nx = shreg;
    load     = 1'b0;
    case (state)
      IDLE: if (slot_full) load = 1'b1;
      SHIFT: begin
        if (per_cnt == '0) begin
          if (bit_cnt == '0) begin
            state_nx = SYNCHI;
          end else begin
            bit_nx = bit_cnt - BW'(1);
            per_nx = PER_MAX;
            for (int k = 0; k < NCH; k++)
              shreg_nx[k*W +: W] = {shreg[k*W +: W-1], 1'b0};
          end
        end else begin
          per_nx = per_cnt - PW'(1);
        end
      end
      SYNCHI: begin
        if (LDAC_W > 0) begin
          state_nx = LDAC;
          ldac_nx  = LDAC_MAX;
        end else if (slot_full) begin
          load = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      LDAC: begin
        if (ldac_cnt == '0) begin
          if (slot_full) load = 1'b1;
          else           state_nx = IDLE;
        end else begin
          ldac_nx = ldac_cnt - LCW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // Loading from LDAC/SYNCHI lets back-to-back frames run without an idle gap.
    if (load) begin
      state_nx = SHIFT;
      shreg_nx = slot;
      per_nx   = PER_MAX;
      bit_nx   = BIT_MAX;
    end
    slot_full_nx = accept ? 1'b1 : (load ? 1'b0 : slot_full);
    for (int k = 0; k < NCH; k++)
      sdo_nx[k] = (state_nx == SHIFT) && shreg_nx[k*W + W - 1];
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt   <= '0;
      bit_cnt   <= '0;
      ldac_cnt  <= '0;
      shreg     <= '0;
      slot      <= '0;
      slot_full <= 1'b0;
      sclk_o    <= 1'b0;
      syncn_o   <= 1'b1;
      ldacn_o   <= 1'b1;
      sdo_o     <= '0;
      busy_o    <= 1'b0;
      ready_o   <= 1'b1;
      ovf_o     <= 1'b0;
    end else begin
      per_cnt   <= per_nx;
      bit_cnt   <= bit_nx;
      ldac_cnt  <= ldac_nx;
      shreg     <= shreg_nx;
      slot_full <= slot_full_nx;
      if (accept) slot <= data_i;
      sclk_o    <= (state_nx == SHIFT) && (per_nx >= DIV_C);
      syncn_o   <= (state_nx != SHIFT);
      ldacn_o   <= (state_nx != LDAC);
      sdo_o     <= sdo_nx;
      busy_o    <= (state_nx != IDLE);
      ready_o   <= !slot_full_nx;
      ovf_o     <= valid_i && !ready_o;
    end
  end

`ifdef GPA_SPI_READBACK_EN
  localparam logic [PW-1:0] FALL_CNT = PW'(DIV - 1);

  logic [NCH*W-1:0] rx_sh, rx_nx;
  logic             sample;

  // First low cycle of each bit period, i.e. the cycle sclk_o drops.
  assign sample = (state == SHIFT) && (per_cnt == FALL_CNT);

  always_comb begin
    rx_nx = rx_sh;
    if (sample)
      for (int k = 0; k < NCH; k++)
        rx_nx[k*W +: W] = {rx_sh[k*W +: W-1], sdi_i[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh    <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rx_sh    <= rx_nx;
      rvalid_o <= (state == SHIFT) && (state_nx == SYNCHI);
      if ((state == SHIFT) && (state_nx == SYNCHI)) rdata_o <= rx_nx;
    end
  end
`endif

endmodule

// File: tb/tb_gpa_spi_serialiser.sv
// Self-checking bench: default instance (A) and a NCH=1/W=16/DIV=1/LDAC_W=0 instance (B),
// both compared every cycle against a frame-timeline model.
module tb_gpa_spi_serialiser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld_a = 1'b0, vld_b = 1'b0;
  logic [95:0] din_a = '0;
  logic [15:0] din_b = '0;
  logic        sck_a, sck_b, syn_a, syn_b, ldn_a, ldn_b, bsy_a, bsy_b, rdy_a, rdy_b, ovf_a, ovf_b;
  logic [3:0]  sdo_a;
  logic [0:0]  sdo_b;
`ifdef GPA_SPI_READBACK_EN
  logic [95:0] rdata_a;
  logic [15:0] rdata_b;
  logic        rv_a, rv_b;
`endif

  gpa_spi_serialiser dut_a (
    .clk(clk), .rst(rst), .data_i(din_a), .valid_i(vld_a), .ready_o(rdy_a), .busy_o(bsy_a),
    .ovf_o(ovf_a), .sclk_o(sck_a), .syncn_o(syn_a), .ldacn_o(ldn_a), .sdo_o(sdo_a)
`ifdef GPA_SPI_READBACK_EN
    , .sdi_i(sdo_a), .rdata_o(rdata_a), .rvalid_o(rv_a)
`endif
  );

  gpa_spi_serialiser #(.NCH(1), .W(16), .DIV(1), .LDAC_W(0)) dut_b (
    .clk(clk), .rst(rst), .data_i(din_b), .valid_i(vld_b), .ready_o(rdy_b), .busy_o(bsy_b),
    .ovf_o(ovf_b), .sclk_o(sck_b), .syncn_o(syn_b), .ldacn_o(ldn_b), .sdo_o(sdo_b)
`ifdef GPA_SPI_READBACK_EN
    , .sdi_i(sdo_b), .rdata_o(rdata_b), .rvalid_o(rv_b)
`endif
  );

  logic [1:0] sck, syn, ldn, bsy, rdy, ovf;
  assign sck = {sck_b, sck_a};
  assign syn = {syn_b, syn_a};
  assign ldn = {ldn_b, ldn_a};
  assign bsy = {bsy_b, bsy_a};
  assign rdy = {rdy_b, rdy_a};
  assign ovf = {ovf_b, ovf_a};

  int n_chk = 0;
  int n_err = 0;
  logic b_done = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int p_nch(int i); return (i == 0) ? 4 : 1;  endfunction
  function automatic int p_w(int i);   return (i == 0) ? 24 : 16; endfunction
  function automatic int p_div(int i); return (i == 0) ? 16 : 1;  endfunction
  function automatic int p_ldw(int i); return (i == 0) ? 4 : 0;   endfunction
  function automatic int p_s(int i);   return p_w(i) * 2 * p_div(i); endfunction
  function automatic int p_fl(int i);  return p_s(i) + 1 + p_ldw(i); endfunction
  function automatic logic vld_i(int i); return (i == 0) ? vld_a : vld_b; endfunction
  function automatic logic [95:0] din_i(int i); return (i == 0) ? din_a : {80'b0, din_b}; endfunction
  function automatic logic [7:0] d_sdo(int i); return (i == 0) ? {4'b0, sdo_a} : {7'b0, sdo_b}; endfunction

  // Model: a frame is a timeline t = 0 .. p_fl-1 starting the cycle after a load.
  logic        m_act  [2];
  int          m_t    [2];
  logic [95:0] m_word [2];
  logic [95:0] m_slot [2];
  logic        m_full [2];
  logic        m_ovf  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_t[i] <= 0; m_word[i] <= '0; m_slot[i] <= '0;
        m_full[i] <= 1'b0; m_ovf[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ovf[i] <= vld_i(i) && m_full[i];
        if (m_act[i] && m_t[i] < p_fl(i) - 1) begin
          m_t[i] <= m_t[i] + 1;
        end else if (m_full[i]) begin
          m_act[i] <= 1'b1; m_t[i] <= 0; m_word[i] <= m_slot[i];
        end else begin
          m_act[i] <= 1'b0;
        end
        if (vld_i(i) && !m_full[i]) begin
          m_full[i] <= 1'b1; m_slot[i] <= din_i(i);
        end else if (m_full[i] && !(m_act[i] && m_t[i] < p_fl(i) - 1)) begin
          m_full[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic e_sh(int i); return m_act[i] && m_t[i] < p_s(i); endfunction
  function automatic logic e_sclk(int i);
    return e_sh(i) && ((m_t[i] % (2 * p_div(i))) < p_div(i));
  endfunction
  function automatic logic e_ldn(int i);
    return !(m_act[i] && m_t[i] > p_s(i) && m_t[i] <= p_s(i) + p_ldw(i));
  endfunction
  function automatic logic [7:0] e_sdo(int i);
    logic [7:0] r = '0;
    if (e_sh(i))
      for (int k = 0; k < p_nch(i); k++)
        r[k] = m_word[i][k*p_w(i) + p_w(i) - 1 - m_t[i] / (2 * p_div(i))];
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sclk%0d", i),  96'(sck[i]),   96'(e_sclk(i)));
      chk($sformatf("syncn%0d", i), 96'(syn[i]),   96'(!e_sh(i)));
      chk($sformatf("ldacn%0d", i), 96'(ldn[i]),   96'(e_ldn(i)));
      chk($sformatf("sdo%0d", i),   96'(d_sdo(i)), 96'(e_sdo(i)));
      chk($sformatf("busy%0d", i),  96'(bsy[i]),   96'(m_act[i]));
      chk($sformatf("ready%0d", i), 96'(rdy[i]),   96'(!m_full[i]));
      chk($sformatf("ovf%0d", i),   96'(ovf[i]),   96'(m_ovf[i]));
    end
`ifdef GPA_SPI_READBACK_EN
    chk("rvalid0", 96'(rv_a), 96'(m_act[0] && m_t[0] == p_s(0)));
    chk("rvalid1", 96'(rv_b), 96'(m_act[1] && m_t[1] == p_s(1)));
    if (m_act[0] && m_t[0] == p_s(0)) chk("rdata0", rdata_a, m_word[0]);
    if (m_act[1] && m_t[1] == p_s(1)) chk("rdata1", {80'b0, rdata_b}, m_word[1]);
`endif
  end

  // Pin-level observer: words recovered on falling sclk edges, run lengths, pulse counts.
  logic [95:0] rxq[$];
  logic [95:0] acc = '0;
  int nbit = 0, sync_run = 0, last_sync = 0;
  logic [1:0] p_sck = 2'b00, p_syn = 2'b11, p_ldn = 2'b11, p_bsy = 2'b00;
  int ldac_run[2] = '{0, 0}, last_ldac[2] = '{0, 0}, ldac_tot[2] = '{0, 0};
  int busy_run[2] = '{0, 0}, last_busy[2] = '{0, 0}, busy_falls[2] = '{0, 0};
  int ovf_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    if (rst) begin
      acc <= '0; nbit <= 0; sync_run <= 0;
      p_sck <= 2'b00; p_syn <= 2'b11; p_ldn <= 2'b11; p_bsy <= 2'b00;
      for (int i = 0; i < 2; i++) begin ldac_run[i] <= 0; busy_run[i] <= 0; end
    end else begin
      if (p_sck[0] && !sck_a && !syn_a) begin
        for (int k = 0; k < 4; k++) acc[k*24 +: 24] <= {acc[k*24 +: 23], sdo_a[k]};
        nbit <= nbit + 1;
      end
      if (!syn_a) sync_run <= sync_run + 1;
      if (!p_syn[0] && syn_a) begin
        last_sync <= sync_run; sync_run <= 0; nbit <= 0;
        rxq.push_back((nbit == 24) ? acc : 96'hDEAD);
      end
      for (int i = 0; i < 2; i++) begin
        if (!ldn[i]) begin ldac_run[i] <= ldac_run[i] + 1; ldac_tot[i] <= ldac_tot[i] + 1; end
        if (!p_ldn[i] && ldn[i]) begin last_ldac[i] <= ldac_run[i]; ldac_run[i] <= 0; end
        if (bsy[i]) busy_run[i] <= busy_run[i] + 1;
        if (p_bsy[i] && !bsy[i]) begin
          last_busy[i] <= busy_run[i]; busy_run[i] <= 0; busy_falls[i] <= busy_falls[i] + 1;
        end
        if (ovf[i]) ovf_cnt[i] <= ovf_cnt[i] + 1;
      end
      p_sck <= sck; p_syn <= syn; p_ldn <= ldn; p_bsy <= bsy;
    end
  end

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic offer_a(input logic [95:0] w);
    @(negedge clk); vld_a = 1'b1; din_a = w;
    @(negedge clk); vld_a = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, input string nm);
    int n = 0;
    while ((bsy[i] || !rdy[i]) && n < budget) begin @(negedge clk); n++; end
    chk(nm, 96'(n < budget), 96'd1);
    @(negedge clk);
  endtask

  // Instance B: 16-bit, DIV=1, no LDAC pulse.
  initial begin
    while (rst) @(negedge clk);
    repeat (2) @(negedge clk);
    @(negedge clk); vld_b = 1'b1; din_b = 16'h1234;
    @(negedge clk); vld_b = 1'b0;
    wait_idle(1, 200, "b_idle_timeout");
    chk("b_busy_len", 96'(last_busy[1]), 96'd33);
    chk("b_ldac_low", 96'(ldac_tot[1]), 96'd0);
    repeat (600) begin
      @(negedge clk);
      vld_b = ($urandom_range(0, 9) == 0);
      din_b = 16'($urandom);
    end
    vld_b = 1'b0;
    wait_idle(1, 200, "b_idle_timeout2");
    chk("b_ldac_low2", 96'(ldac_tot[1]), 96'd0);
    b_done = 1'b1;
  end

  initial begin
    logic [95:0] w1, w2, w3, w4, w5, w6;
    int n, falls0, ovf0;
    w1 = {24'hA5F00F, 24'h000001, 24'h800000, 24'hFFFFFF};
    repeat (3) @(negedge clk);
    chk("rst_busy",  96'(bsy_a), 96'd0);
    chk("rst_ready", 96'(rdy_a), 96'd1);
    chk("rst_syncn", 96'(syn_a), 96'd1);
    chk("rst_ldacn", 96'(ldn_a), 96'd1);
    chk("rst_sclk",  96'(sck_a), 96'd0);
    chk("rst_sdo",   96'(sdo_a), 96'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame with the reference words.
    rxq.delete();
    offer_a(w1);
    chk("c1_ready", 96'(rdy_a), 96'd0);
    chk("c1_syncn", 96'(syn_a), 96'd1);
    @(negedge clk);
    chk("c2_syncn", 96'(syn_a), 96'd0);
    chk("c2_sdo",   96'(sdo_a), 96'b1011);
    chk("c2_sclk",  96'(sck_a), 96'd1);
    chk("c2_busy",  96'(bsy_a), 96'd1);
    chk("c2_ready", 96'(rdy_a), 96'd1);
    wait_idle(0, 2000, "f1_timeout");
    chk("f1_sync_len", 96'(last_sync),    96'd768);
    chk("f1_ldac_len", 96'(last_ldac[0]), 96'd4);
    chk("f1_busy_len", 96'(last_busy[0]), 96'd773);
    chk("f1_nwords",   96'(rxq.size()),   96'd1);
    if (rxq.size() > 0) chk("f1_word", rxq[0], w1);

    // Back-to-back frames plus one overflowed word.
    rxq.delete();
    falls0 = busy_falls[0]; ovf0 = ovf_cnt[0];
    w2 = rand96(); w3 = rand96(); w4 = rand96();
    offer_a(w2);
    repeat (98) @(negedge clk);
    offer_a(w3);
    chk("b2b_ready_low", 96'(rdy_a), 96'd0);
    repeat (30) @(negedge clk);
    offer_a(w4);
    chk("ovf_pulse", 96'(ovf_a), 96'd1);
    @(negedge clk);
    chk("ovf_single", 96'(ovf_a), 96'd0);
    wait_idle(0, 3000, "b2b_timeout");
    chk("b2b_busy_falls", 96'(busy_falls[0] - falls0), 96'd1);
    chk("b2b_ovf_count",  96'(ovf_cnt[0] - ovf0),     96'd1);
    chk("b2b_nwords",     96'(rxq.size()),            96'd2);
    if (rxq.size() > 1) begin
      chk("b2b_word0", rxq[0], w2);
      chk("b2b_word1", rxq[1], w3);
    end

    // Random offers, including ones that collide with a full slot.
    repeat (3000) begin
      @(negedge clk);
      vld_a = ($urandom_range(0, 199) == 0);
      din_a = rand96();
    end
    vld_a = 1'b0;
    wait_idle(0, 3000, "rnd_timeout");
    n = 0;
    while (!b_done && n < 2000) begin @(negedge clk); n++; end
    chk("b_done_timeout", 96'(b_done), 96'd1);

    // Asynchronous reset in the middle of bit 10.
    rxq.delete();
    w5 = rand96();
    offer_a(w5);
    n = 0;
    while (nbit != 10 && n < 1000) begin @(negedge clk); n++; end
    chk("bit10_timeout", 96'(n < 1000), 96'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  96'(bsy_a), 96'd0);
    chk("arst_syncn", 96'(syn_a), 96'd1);
    chk("arst_sclk",  96'(sck_a), 96'd0);
    chk("arst_sdo",   96'(sdo_a), 96'd0);
    chk("arst_ldacn", 96'(ldn_a), 96'd1);
    chk("arst_ready", 96'(rdy_a), 96'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w6 = rand96();
    offer_a(w6);
    wait_idle(0, 2000, "post_rst_timeout");
    chk("post_rst_nwords", 96'(rxq.size()), 96'd1);
    if (rxq.size() > 0) chk("post_rst_word", rxq[0], w6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
